tank_monitor_scanner: RTL

// - Parametrised N-channel aquarium sensor store (fish count, cleanliness, temperature, food, salinity, ...).
// - Per channel: value register, high-limit register, over-limit alarm.
// - Drives one display bus in hold, round-robin scan or alarm-only scan mode.
// - Sticky error mode forces an all-ones code onto the display.

---
 rtl/tank_mon_pkg.sv | 26 ++
 rtl/tank_mon_if.sv | 39 +++
 rtl/tank_mon_chan.sv | 50 +++++
 rtl/tank_monitor_scanner.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/tank_mon_pkg.sv
// Shared types and helpers for the aquarium sensor monitor.
// Mode/state encodings, channel-index width and the error display code.
package tank_mon_pkg;

  typedef enum logic [1:0] {
    HOLD       = 2'd0,
    SCAN       = 2'd1,
    ALARM_SCAN = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    S_HOLD,
    S_SCAN,
    S_ASCAN,
    S_ERR
  } state_t;

  function automatic logic [63:0] err_code();
    return '1;
  endfunction

  function automatic int ch_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tank_mon_if.sv
// Write port, display bus and status bundle of the tank monitor.
// master drives writes/mode, slave is the monitor itself.
interface tank_mon_if
  import tank_mon_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 8
) ();

  localparam int CH_W = ch_w(NUM_CH);

  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic              wr_kind;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        mode;
  logic [CH_W-1:0]   sel_ch;
  logic              err_clr;
  logic [DATA_W-1:0] disp_data;
  logic [CH_W-1:0]   disp_ch;
  logic              disp_valid;
  logic [NUM_CH-1:0] alarm_vec;
  logic              err;

  modport master (
    output wr_en, wr_ch, wr_kind, wr_data,
    output mode, sel_ch, err_clr,
    input  disp_data, disp_ch, disp_valid,
    input  alarm_vec, err
  );

  modport slave (
    input  wr_en, wr_ch, wr_kind, wr_data,
    input  mode, sel_ch, err_clr,
    output disp_data, disp_ch, disp_valid,
    output alarm_vec, err
  );

endinterface

// File: rtl/tank_mon_chan.sv
// One sensor channel: value and limit registers plus a registered
// over-limit alarm (strictly greater, unsigned).
module tank_chan_reg
  import tank_mon_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH_W   = 3,
  parameter int IDX    = 0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic              wr_kind,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] val,
  output logic              alarm
);

  logic [DATA_W-1:0] val_q, val_d;
  logic [DATA_W-1:0] lim_q, lim_d;
  logic              alarm_q, alarm_d;
  logic              hit;

  assign hit = wr_en && (wr_ch == CH_W'(IDX));

  always_comb begin
    val_d   = val_q;
    lim_d   = lim_q;
    alarm_d = val_q > lim_q;
    if (hit && !wr_kind) val_d = wr_data;
    if (hit && wr_kind)  lim_d = wr_data;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      val_q   <= '0;
      lim_q   <= '1;
      alarm_q <= 1'b0;
    end else begin
      val_q   <= val_d;
      lim_q   <= lim_d;
      alarm_q <= alarm_d;
    end
  end

  assign val   = val_q;
  assign alarm = alarm_q;

endmodule

// File: rtl/tank_monitor_scanner.sv
// N-channel tank sensor store with hold / round-robin / alarm-only
// display scanning and a sticky error display.
module tank_monitor_scanner
  import tank_mon_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 8,
  parameter int DWELL  = 4
) (
  input logic       CLK,
  input logic       reset,
  tank_mon_if.slave bus
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [DATA_W-1:0] ERR_D   = DATA_W'(err_code());
  localparam logic [CH_W-1:0]   ERR_C   = CH_W'(err_code());
  localparam logic [CH_W-1:0]   LAST    = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]     NCH     = (CH_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DWELL - 1);

  logic [DATA_W-1:0] val [NUM_CH];
  logic [NUM_CH-1:0] alarm;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tank_chan_reg #(
      .DATA_W (DATA_W),
      .CH_W   (CH_W),
      .IDX    (g)
    ) u_ch (
      .CLK     (CLK),
      .reset   (reset),
      .wr_en   (bus.wr_en),
      .wr_ch   (bus.wr_ch),
      .wr_kind (bus.wr_kind),
      .wr_data (bus.wr_data),
      .val     (val[g]),
      .alarm   (alarm[g])
    );
  end

  state_t            state_q, state_d;
  logic              err_q, err_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [CH_W-1:0]   disp_ch_q, disp_ch_d;
  logic              disp_valid_q, disp_valid_d;

  logic            wr_bad;
  logic            sel_ok;
  logic [CH_W-1:0] sel_i;
  logic [CH_W-1:0] nxt;
  int              j;

  assign wr_bad = bus.wr_en && ({1'b0, bus.wr_ch} >= NCH);
  assign sel_ok = {1'b0, bus.sel_ch} < NCH;
  assign sel_i  = sel_ok ? bus.sel_ch : '0;

  // Circular search from ptr+1; lowest offset wins, ptr itself is last.
  always_comb begin
    nxt = ptr_q;
    j   = 0;
    for (int i = NUM_CH; i >= 1; i--) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (alarm[CH_W'(j)]) nxt = CH_W'(j);
    end
  end

  always_comb begin
    err_d = err_q;
    if (bus.err_clr) err_d = 1'b0;
    if (wr_bad)      err_d = 1'b1;

    if (err_q)                          state_d = S_ERR;
    else if (bus.mode == SCAN)          state_d = S_SCAN;
    else if (bus.mode == ALARM_SCAN)    state_d = S_ASCAN;
    else                                state_d = S_HOLD;

    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        S_SCAN: begin
          if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + CH_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_ASCAN: begin
          if (alarm == '0) begin
            cnt_d = '0;
          end else if (!alarm[ptr_q] || cnt_q == CNT_MAX) begin
            cnt_d = '0;
            ptr_d = nxt;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: cnt_d = '0;
      endcase
    end

    disp_data_d  = '0;
    disp_ch_d    = ptr_q;
    disp_valid_d = 1'b0;
    case (state_q)
      S_HOLD: begin
        disp_ch_d    = bus.sel_ch;
        disp_valid_d = sel_ok;
        disp_data_d  = sel_ok ? val[sel_i] : '0;
      end
      S_SCAN: begin
        disp_valid_d = 1'b1;
        disp_data_d  = val[ptr_q];
      end
      S_ASCAN: begin
        disp_valid_d = |alarm;
        disp_data_d  = (|alarm) ? val[ptr_q] : '0;
      end
      default: begin
        disp_ch_d    = ERR_C;
        disp_valid_d = 1'b1;
        disp_data_d  = ERR_D;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= S_HOLD;
      err_q        <= 1'b0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      disp_data_q  <= '0;
      disp_ch_q    <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      disp_data_q  <= disp_data_d;
      disp_ch_q    <= disp_ch_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign bus.disp_data  = disp_data_q;
  assign bus.disp_ch    = disp_ch_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.alarm_vec  = alarm;
  assign bus.err        = err_q;

endmodule
